xorshift_mc: RTL and testbench

XORSHIFT_MC -- requirements
Module: xorshift_mc

---
 rtl/xorshift_mc_pkg.sv | 32 +++
 rtl/xorshift_mc_ch.sv | 94 +++++++++
 rtl/xorshift_mc.sv | 120 ++++++++++++
 tb/tb_xorshift_mc.sv | 192 +++++++++++++++++++
 4 files changed

// File: rtl/xorshift_mc_pkg.sv
// Shared constants and types for the multi-channel xorshift PRNG block:
// register offsets, shift amounts per state width and the decoded access.
package xorshift_mc_pkg;

  typedef struct packed {
    int unsigned IdWidth;
  } obi_cfg_t;

  localparam obi_cfg_t SbrObiCfg = '{IdWidth: 32'd4};

  localparam logic [2:0] REG_CTRL    = 3'd0;
  localparam logic [2:0] REG_DATA_LO = 3'd1;
  localparam logic [2:0] REG_DATA_HI = 3'd2;
  localparam logic [2:0] REG_SEED_LO = 3'd3;
  localparam logic [2:0] REG_SEED_HI = 3'd4;
  localparam logic [2:0] REG_COUNT   = 3'd5;

  localparam int unsigned SH32_A = 13;
  localparam int unsigned SH32_B = 17;
  localparam int unsigned SH32_C = 5;
  localparam int unsigned SH64_A = 13;
  localparam int unsigned SH64_B = 7;
  localparam int unsigned SH64_C = 17;

  typedef struct packed {
    logic [3:0] ch;
    logic [2:0] rg;
    logic       we;
    logic       err;
  } access_t;

endpackage

// File: rtl/xorshift_mc_ch.sv
// One xorshift channel: state, step, seed staging/commit, read-advance,
// high-half snapshot and (with XORSHIFT_MC_DRAW_CNT_EN) a draw counter.
module xorshift_ch
  import xorshift_mc_pkg::*;
#(
  parameter int unsigned PRNG_WIDTH = 32,
  parameter logic [63:0] PRNG_SEED  = 64'h0000_0000_DEAD_BEEF
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  sel_i,
  input  logic                  we_i,
  input  logic [2:0]            reg_i,
  input  logic [31:0]           wdata_i,
  output logic [PRNG_WIDTH-1:0] state_o,
  output logic                  rd_adv_o,
  output logic [31:0]           hi_snap_o
`ifdef XORSHIFT_MC_DRAW_CNT_EN
  ,
  output logic [31:0]           count_o
`endif
);

  localparam logic [PRNG_WIDTH-1:0] SEED = PRNG_SEED[PRNG_WIDTH-1:0];
  localparam int unsigned SA = (PRNG_WIDTH == 64) ? SH64_A : SH32_A;
  localparam int unsigned SB = (PRNG_WIDTH == 64) ? SH64_B : SH32_B;
  localparam int unsigned SC = (PRNG_WIDTH == 64) ? SH64_C : SH32_C;

  logic [PRNG_WIDTH-1:0] state_q, state_d, t1, t2, step_val, seed_val;
  logic                  rd_adv_q;
  logic                  wr, rd, do_step, commit;

  assign wr = sel_i & we_i;
  assign rd = sel_i & ~we_i;
  assign do_step = (wr && reg_i == REG_CTRL && wdata_i[0]) ||
                   (rd && reg_i == REG_DATA_LO && rd_adv_q);

  always_comb begin
    t1       = state_q ^ (state_q << SA);
    t2       = t1 ^ (t1 >> SB);
    step_val = t2 ^ (t2 << SC);
  end

  // 64-bit channels commit on the high word; 32-bit ones commit immediately.
  if (PRNG_WIDTH == 64) begin : g_w64
    logic [31:0] seed_lo_q, hi_snap_q;
    assign commit   = wr && reg_i == REG_SEED_HI;
    assign seed_val = {wdata_i, seed_lo_q};
    always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
        seed_lo_q <= '0;
        hi_snap_q <= '0;
      end else begin
        if (wr && reg_i == REG_SEED_LO) seed_lo_q <= wdata_i;
        if (rd && reg_i == REG_DATA_LO) hi_snap_q <= state_q[63:32];
      end
    end
    assign hi_snap_o = hi_snap_q;
  end else begin : g_w32
    assign commit    = wr && reg_i == REG_SEED_LO;
    assign seed_val  = wdata_i;
    assign hi_snap_o = '0;
  end

  always_comb begin
    state_d = state_q;
    if (commit) state_d = (seed_val == '0) ? SEED : seed_val;
    else if (do_step) state_d = step_val;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q  <= SEED;
      rd_adv_q <= 1'b0;
    end else begin
      state_q <= state_d;
      if (wr && reg_i == REG_CTRL) rd_adv_q <= wdata_i[1];
    end
  end

`ifdef XORSHIFT_MC_DRAW_CNT_EN
  logic [31:0] count_q;
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) count_q <= '0;
    else if (commit) count_q <= '0;
    else if (do_step) count_q <= count_q + 32'd1;
  end
  assign count_o = count_q;
`endif

  assign state_o  = state_q;
  assign rd_adv_o = rd_adv_q;

endmodule

// File: rtl/xorshift_mc.sv
// Multi-channel xorshift PRNG behind an OBI subordinate port.
// Define XORSHIFT_MC_DRAW_CNT_EN to add a per-channel COUNT register.
module xorshift_mc
  import xorshift_mc_pkg::*;
#(
  parameter int unsigned NUM_CH       = 4,
  parameter int unsigned PRNG_WIDTH   = 32,
  parameter logic [63:0] PRNG_SEED    = 64'h0000_0000_DEAD_BEEF,
  parameter int unsigned ID_WIDTH_OBI = SbrObiCfg.IdWidth
) (
  input  logic                         clk_i,
  input  logic                         rst_ni,
  input  logic                         req_i,
  input  logic                         we_i,
  input  logic [3:0]                   be_i,
  input  logic [31:0]                  addr_i,
  input  logic [31:0]                  wdata_i,
  input  logic [ID_WIDTH_OBI-1:0]      aid_i,
  output logic                         gnt_o,
  output logic                         rvalid_o,
  output logic [31:0]                  rdata_o,
  output logic [ID_WIDTH_OBI-1:0]      rid_o,
  output logic                         err_o,
  output logic [NUM_CH*PRNG_WIDTH-1:0] current_prn_o
);

  access_t                acc;
  logic [PRNG_WIDTH-1:0]  ch_state   [NUM_CH];
  logic                   ch_rd_adv  [NUM_CH];
  logic [31:0]            ch_hi_snap [NUM_CH];
`ifdef XORSHIFT_MC_DRAW_CNT_EN
  logic [31:0]            ch_count   [NUM_CH];
`endif
  logic [31:0]            rd_word;
  logic                   rvalid_q, err_q;
  logic [31:0]            rdata_q;
  logic [ID_WIDTH_OBI-1:0] rid_q;
  logic                   unused_bits;

  assign unused_bits = ^{be_i, addr_i[31:9], addr_i[1:0]};
  assign gnt_o = req_i;

  always_comb begin
    acc.ch  = addr_i[8:5];
    acc.rg  = addr_i[4:2];
    acc.we  = we_i;
    acc.err = ({1'b0, acc.ch} >= 5'(NUM_CH));
    case (acc.rg)
      REG_CTRL:    ;
      REG_DATA_LO: if (acc.we) acc.err = 1'b1;
      REG_DATA_HI: if (acc.we || PRNG_WIDTH == 32) acc.err = 1'b1;
      REG_SEED_LO: if (!acc.we) acc.err = 1'b1;
      REG_SEED_HI: if (!acc.we || PRNG_WIDTH == 32) acc.err = 1'b1;
`ifdef XORSHIFT_MC_DRAW_CNT_EN
      REG_COUNT:   if (acc.we) acc.err = 1'b1;
`endif
      default:     acc.err = 1'b1;
    endcase
  end

  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    xorshift_ch #(
      .PRNG_WIDTH(PRNG_WIDTH),
      .PRNG_SEED (PRNG_SEED)
    ) u_ch (
      .clk_i    (clk_i),
      .rst_ni   (rst_ni),
      .sel_i    (req_i && !acc.err && acc.ch == 4'(g)),
      .we_i     (acc.we),
      .reg_i    (acc.rg),
      .wdata_i  (wdata_i),
      .state_o  (ch_state[g]),
      .rd_adv_o (ch_rd_adv[g]),
      .hi_snap_o(ch_hi_snap[g])
`ifdef XORSHIFT_MC_DRAW_CNT_EN
      ,
      .count_o  (ch_count[g])
`endif
    );
    assign current_prn_o[g*PRNG_WIDTH +: PRNG_WIDTH] = ch_state[g];
  end

  always_comb begin
    rd_word = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (acc.ch == 4'(i)) begin
        case (acc.rg)
          REG_CTRL:    rd_word = {30'b0, ch_rd_adv[i], 1'b0};
          REG_DATA_LO: rd_word = ch_state[i][31:0];
          REG_DATA_HI: rd_word = ch_hi_snap[i];
`ifdef XORSHIFT_MC_DRAW_CNT_EN
          REG_COUNT:   rd_word = ch_count[i];
`endif
          default:     ;
        endcase
      end
    end
  end

  // Read data is sampled in the request cycle, before any read-advance step lands.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rvalid_q <= 1'b0;
      err_q    <= 1'b0;
      rdata_q  <= '0;
      rid_q    <= '0;
    end else begin
      rvalid_q <= req_i;
      err_q    <= req_i && acc.err;
      rdata_q  <= (req_i && !acc.err && !acc.we) ? rd_word : '0;
      if (req_i) rid_q <= aid_i;
    end
  end

  assign rvalid_o = rvalid_q;
  assign err_o    = err_q;
  assign rdata_o  = rdata_q;
  assign rid_o    = rid_q;

endmodule

// File: tb/tb_xorshift_mc.sv
// Directed bench for xorshift_mc: a 4x32-bit instance and a 2x64-bit instance.
module tb_xorshift_mc;
  import xorshift_mc_pkg::*;

  localparam int IDW = SbrObiCfg.IdWidth;

  logic           clk_i = 1'b0;
  logic           rst_ni = 1'b0;
  logic           req32 = 1'b0, req64 = 1'b0;
  logic           we_i = 1'b0;
  logic [3:0]     be_i = 4'hF;
  logic [31:0]    addr_i = '0, wdata_i = '0;
  logic [IDW-1:0] aid_i = '0;

  logic           gnt32, rvalid32, err32, gnt64, rvalid64, err64;
  logic [31:0]    rdata32, rdata64;
  logic [IDW-1:0] rid32, rid64;
  logic [127:0]   prn32, prn64;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk_i = ~clk_i;

  xorshift_mc #(.NUM_CH(4), .PRNG_WIDTH(32)) dut32 (
    .clk_i(clk_i), .rst_ni(rst_ni), .req_i(req32), .we_i(we_i), .be_i(be_i),
    .addr_i(addr_i), .wdata_i(wdata_i), .aid_i(aid_i), .gnt_o(gnt32),
    .rvalid_o(rvalid32), .rdata_o(rdata32), .rid_o(rid32), .err_o(err32),
    .current_prn_o(prn32));

  xorshift_mc #(.NUM_CH(2), .PRNG_WIDTH(64)) dut64 (
    .clk_i(clk_i), .rst_ni(rst_ni), .req_i(req64), .we_i(we_i), .be_i(be_i),
    .addr_i(addr_i), .wdata_i(wdata_i), .aid_i(aid_i), .gnt_o(gnt64),
    .rvalid_o(rvalid64), .rdata_o(rdata64), .rid_o(rid64), .err_o(err64),
    .current_prn_o(prn64));

  task automatic xact(input bit d64, input bit we, input logic [31:0] addr,
                      input logic [31:0] wd, input logic [IDW-1:0] aid,
                      output logic [31:0] rd, output logic e, output logic v,
                      output logic [IDW-1:0] id);
    @(negedge clk_i);
    we_i = we; addr_i = addr; wdata_i = wd; aid_i = aid; be_i = 4'h3;
    if (d64) req64 = 1'b1; else req32 = 1'b1;
    @(posedge clk_i); #1;
    req32 = 1'b0; req64 = 1'b0;
    if (d64) begin rd = rdata64; e = err64; v = rvalid64; id = rid64; end
    else begin rd = rdata32; e = err32; v = rvalid32; id = rid32; end
  endtask

  task automatic test_reset;
    logic [31:0] rd; logic e, v; logic [IDW-1:0] id;
    rst_ni = 1'b0;
    repeat (3) @(posedge clk_i);
    #1;
    n_cmp++; if (rvalid32 !== 1'b0) begin n_bad++; $display("FAIL reset_rvalid: got %b want 0", rvalid32); end
    n_cmp++; if (err32 !== 1'b0 || rid32 !== '0 || rdata32 !== '0) begin n_bad++; $display("FAIL reset_resp: err %b rid %h rdata %h want all 0", err32, rid32, rdata32); end
    n_cmp++; if (prn32 !== {4{32'hDEADBEEF}}) begin n_bad++; $display("FAIL reset_prn32: got %h want %h", prn32, {4{32'hDEADBEEF}}); end
    n_cmp++; if (prn64 !== {2{64'h0000_0000_DEAD_BEEF}}) begin n_bad++; $display("FAIL reset_prn64: got %h want %h", prn64, {2{64'h0000_0000_DEAD_BEEF}}); end
    @(negedge clk_i); rst_ni = 1'b1;
    xact(0, 0, 32'h04, 32'h0, 4'h5, rd, e, v, id);
    n_cmp++; if (v !== 1'b1) begin n_bad++; $display("FAIL first_rvalid: got %b want 1", v); end
    n_cmp++; if (rd !== 32'hDEADBEEF) begin n_bad++; $display("FAIL first_rdata: got %h want deadbeef", rd); end
    n_cmp++; if (e !== 1'b0 || id !== 4'h5) begin n_bad++; $display("FAIL first_err_rid: err %b rid %h want 0 5", e, id); end
    @(posedge clk_i); #1;
    n_cmp++; if (rvalid32 !== 1'b0 || rdata32 !== '0) begin n_bad++; $display("FAIL rvalid_single: rvalid %b rdata %h want 0 0", rvalid32, rdata32); end
  endtask

  task automatic test_step;
    logic [31:0] rd; logic e, v; logic [IDW-1:0] id;
    xact(0, 1, 32'h2C, 32'h1, 4'h1, rd, e, v, id);
    xact(0, 1, 32'h20, 32'h1, 4'h2, rd, e, v, id);
    n_cmp++; if (e !== 1'b0 || rd !== '0) begin n_bad++; $display("FAIL ctrl_write_resp: err %b rdata %h want 0 0", e, rd); end
    xact(0, 0, 32'h24, 32'h0, 4'h3, rd, e, v, id);
    n_cmp++; if (rd !== 32'h0004_2021) begin n_bad++; $display("FAIL step_ch1: got %h want 00042021", rd); end
    n_cmp++; if (prn32[31:0] !== 32'hDEADBEEF) begin n_bad++; $display("FAIL step_ch0_untouched: got %h want deadbeef", prn32[31:0]); end
    n_cmp++; if (prn32[63:32] !== 32'h0004_2021) begin n_bad++; $display("FAIL step_prn_ch1: got %h want 00042021", prn32[63:32]); end
  endtask

  task automatic test_rd_adv;
    logic [31:0] rd; logic e, v; logic [IDW-1:0] id;
    xact(0, 1, 32'h2C, 32'h1, 4'h0, rd, e, v, id);
    xact(0, 1, 32'h20, 32'h2, 4'h0, rd, e, v, id);
    xact(0, 0, 32'h20, 32'h0, 4'h0, rd, e, v, id);
    n_cmp++; if (rd !== 32'h2) begin n_bad++; $display("FAIL ctrl_readback: got %h want 2", rd); end
    xact(0, 0, 32'h24, 32'h0, 4'h0, rd, e, v, id);
    n_cmp++; if (rd !== 32'h1) begin n_bad++; $display("FAIL rdadv_read1: got %h want 1", rd); end
    xact(0, 0, 32'h24, 32'h0, 4'h0, rd, e, v, id);
    n_cmp++; if (rd !== 32'h0004_2021) begin n_bad++; $display("FAIL rdadv_read2: got %h want 00042021", rd); end
    xact(0, 0, 32'h34, 32'h0, 4'h0, rd, e, v, id);
`ifdef XORSHIFT_MC_DRAW_CNT_EN
    n_cmp++; if (e !== 1'b0 || rd !== 32'd2) begin n_bad++; $display("FAIL count: err %b got %h want 0 2", e, rd); end
`else
    n_cmp++; if (e !== 1'b1 || rd !== 32'd0) begin n_bad++; $display("FAIL count_disabled: err %b rdata %h want 1 0", e, rd); end
`endif
    xact(0, 0, 32'h24, 32'h0, 4'h0, rd, e, v, id);
    n_cmp++; if (rd !== 32'h0408_0601) begin n_bad++; $display("FAIL rdadv_read3: got %h want 04080601", rd); end
  endtask

  task automatic test_zero_seed;
    logic [31:0] rd; logic e, v; logic [IDW-1:0] id;
    xact(0, 1, 32'h4C, 32'h1234_5678, 4'h0, rd, e, v, id);
    xact(0, 0, 32'h44, 32'h0, 4'h0, rd, e, v, id);
    n_cmp++; if (rd !== 32'h1234_5678) begin n_bad++; $display("FAIL seed_ch2: got %h want 12345678", rd); end
    xact(0, 1, 32'h40, 32'h1, 4'h0, rd, e, v, id);
    xact(0, 1, 32'h4C, 32'h0, 4'h0, rd, e, v, id);
    n_cmp++; if (prn32[95:64] !== 32'hDEADBEEF) begin n_bad++; $display("FAIL zero_seed_prn: got %h want deadbeef", prn32[95:64]); end
    xact(0, 0, 32'h44, 32'h0, 4'h0, rd, e, v, id);
    n_cmp++; if (rd !== 32'hDEADBEEF) begin n_bad++; $display("FAIL zero_seed_read: got %h want deadbeef", rd); end
  endtask

  task automatic test_errors;
    logic [31:0] rd; logic e, v; logic [IDW-1:0] id;
    logic [32:0] tbl [8];
    logic [127:0] exp_prn;
    tbl[0] = {1'b0, 32'h84}; tbl[1] = {1'b1, 32'h80}; tbl[2] = {1'b1, 32'h24};
    tbl[3] = {1'b0, 32'h2C}; tbl[4] = {1'b0, 32'h18}; tbl[5] = {1'b0, 32'h08};
    tbl[6] = {1'b1, 32'h10}; tbl[7] = {1'b1, 32'h34};
    xact(0, 1, 32'h2C, 32'h1, 4'h0, rd, e, v, id);
    exp_prn = {32'hDEADBEEF, 32'hDEADBEEF, 32'h1, 32'hDEADBEEF};
    for (int i = 0; i < 8; i++) begin
      xact(0, tbl[i][32], tbl[i][31:0], 32'h3, 4'(i), rd, e, v, id);
      n_cmp++; if (v !== 1'b1 || e !== 1'b1 || rd !== '0) begin n_bad++; $display("FAIL err_case%0d: rvalid %b err %b rdata %h want 1 1 0", i, v, e, rd); end
    end
    n_cmp++; if (prn32 !== exp_prn) begin n_bad++; $display("FAIL err_no_change: got %h want %h", prn32, exp_prn); end
    xact(0, 0, 32'h20, 32'h0, 4'h0, rd, e, v, id);
    n_cmp++; if (rd !== 32'h2) begin n_bad++; $display("FAIL err_ctrl_kept: got %h want 2", rd); end
  endtask

  task automatic test_w64;
    logic [31:0] rd; logic e, v; logic [IDW-1:0] id;
    xact(1, 1, 32'h0C, 32'h0, 4'h0, rd, e, v, id);
    n_cmp++; if (prn64[63:0] !== 64'h0000_0000_DEAD_BEEF) begin n_bad++; $display("FAIL w64_stage_only: got %h want 00000000deadbeef", prn64[63:0]); end
    xact(1, 1, 32'h10, 32'h1, 4'h0, rd, e, v, id);
    n_cmp++; if (prn64[63:0] !== 64'h0000_0001_0000_0000) begin n_bad++; $display("FAIL w64_commit: got %h want 0000000100000000", prn64[63:0]); end
    xact(1, 1, 32'h00, 32'h2, 4'h0, rd, e, v, id);
    xact(1, 0, 32'h04, 32'h0, 4'h0, rd, e, v, id);
    n_cmp++; if (rd !== 32'h0) begin n_bad++; $display("FAIL w64_lo1: got %h want 0", rd); end
    xact(1, 0, 32'h08, 32'h0, 4'h0, rd, e, v, id);
    n_cmp++; if (rd !== 32'h1 || e !== 1'b0) begin n_bad++; $display("FAIL w64_hi1: got %h err %b want 1 0", rd, e); end
    n_cmp++; if (prn64[63:0] !== 64'h4082_2441_0200_0000) begin n_bad++; $display("FAIL w64_step: got %h want 4082244102000000", prn64[63:0]); end
    xact(1, 0, 32'h04, 32'h0, 4'h0, rd, e, v, id);
    n_cmp++; if (rd !== 32'h0200_0000) begin n_bad++; $display("FAIL w64_lo2: got %h want 02000000", rd); end
    xact(1, 0, 32'h08, 32'h0, 4'h0, rd, e, v, id);
    n_cmp++; if (rd !== 32'h4082_2441) begin n_bad++; $display("FAIL w64_hi2: got %h want 40822441", rd); end
    xact(1, 0, 32'h10, 32'h0, 4'h0, rd, e, v, id);
    n_cmp++; if (e !== 1'b1 || rd !== '0) begin n_bad++; $display("FAIL w64_seedhi_read: err %b rdata %h want 1 0", e, rd); end
    n_cmp++; if (prn64[127:64] !== 64'h0000_0000_DEAD_BEEF) begin n_bad++; $display("FAIL w64_ch1_untouched: got %h want 00000000deadbeef", prn64[127:64]); end
  endtask

  task automatic test_back_to_back;
    logic [31:0] rd; logic e, v; logic [IDW-1:0] id;
    int nv;
    nv = 0;
    @(negedge clk_i);
    we_i = 1'b0; addr_i = 32'h04; req32 = 1'b1;
    for (int k = 1; k <= 4; k++) begin
      aid_i = 4'(k);
      #1;
      n_cmp++; if (gnt32 !== 1'b1) begin n_bad++; $display("FAIL b2b_gnt%0d: got %b want 1", k, gnt32); end
      @(posedge clk_i); #1;
      if (rvalid32 === 1'b1) nv++;
      n_cmp++; if (rid32 !== 4'(k) || rdata32 !== 32'hDEADBEEF) begin n_bad++; $display("FAIL b2b_resp%0d: rid %h rdata %h want %h deadbeef", k, rid32, rdata32, 4'(k)); end
      @(negedge clk_i);
    end
    rst_ni = 1'b0;
    #1;
    n_cmp++; if (rvalid32 !== 1'b0) begin n_bad++; $display("FAIL b2b_reset_drop: got %b want 0", rvalid32); end
    req32 = 1'b0;
    repeat (2) @(posedge clk_i);
    @(negedge clk_i); rst_ni = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(posedge clk_i); #1;
      if (rvalid32 === 1'b1) nv++;
    end
    n_cmp++; if (nv != 4) begin n_bad++; $display("FAIL b2b_rvalid_count: got %0d want 4", nv); end
    xact(0, 0, 32'h04, 32'h0, 4'hA, rd, e, v, id);
    n_cmp++; if (v !== 1'b1 || id !== 4'hA || rd !== 32'hDEADBEEF) begin n_bad++; $display("FAIL b2b_after_reset: rvalid %b rid %h rdata %h want 1 a deadbeef", v, id, rd); end
  endtask

  initial begin
    test_reset();
    test_step();
    test_rd_adv();
    test_zero_seed();
    test_errors();
    test_w64();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
